buzzer_player: RTL and testbench

//  Melody sequencer driving the buzzer tone generator. Walks a fixed note table, holding each

---
 rtl/buzzer_player.sv | 174 +++++++++++++++++
 tb/tb_buzzer_player.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_player.sv
// buzzer_player: walks a fixed note table and drives the buzzer tone generator (buzz_en/tone).
// Define PLAYER_LOOP_EN to add a `loop` input that restarts the song from DONE instead of idling.
module buzzer_player #(
  parameter int BEAT_CYC = 1_500_000,
  parameter int GAP_CYC  = 120_000,
  parameter int SONG_LEN = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
`ifdef PLAYER_LOOP_EN
  input  logic              loop,
`endif
  output logic              busy,
  output logic              done,
  output logic              buzz_en,
  output logic [4:0]        tone,
  output logic [ADDR_W-1:0] note_idx
);

  localparam int BEAT_W = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  localparam int GAP_W  = $clog2(GAP_CYC + 1);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYC - 1);
  // The FETCH cycle of the next note is the last silent cycle, so GAP itself runs GAP_CYC-1 cycles.
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(SONG_LEN - 1);
  localparam logic [4:0]        TONE_END  = 5'd31;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Entry layout is {tone[4:0], dur[2:0]}; everything past the melody is the end marker.
  function automatic logic [7:0] note_rom(input logic [ADDR_W-1:0] a);
    logic [31:0] ai;
    ai = 32'(a);
    case (ai)
      32'd0, 32'd1: note_rom = {5'd8, 3'd0};
      32'd2, 32'd3: note_rom = {5'd12, 3'd0};
      32'd4, 32'd5: note_rom = {5'd13, 3'd0};
      32'd6:        note_rom = {5'd12, 3'd1};
      32'd7:        note_rom = {5'd0, 3'd0};
      default:      note_rom = {TONE_END, 3'd0};
    endcase
  endfunction

  function automatic logic audible(input logic [4:0] t);
    audible = (t >= 5'd1) && (t <= 5'd21);
  endfunction

  logic [2:0]        r_state;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [2:0]        r_beat_num;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [2:0]        r_dur;

  logic [7:0] w_entry;
  logic [4:0] w_tone;
  logic [2:0] w_dur;
  logic       w_last;
  logic       w_loop;

  assign w_entry = note_rom(note_idx);
  assign w_tone  = w_entry[7:3];
  assign w_dur   = w_entry[2:0];
  assign w_last  = (note_idx == LAST_IDX);

`ifdef PLAYER_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (r_state == S_FETCH) r_dur <= w_dur;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      buzz_en    <= 1'b0;
      tone       <= 5'd0;
      note_idx   <= '0;
      r_beat_cnt <= '0;
      r_beat_num <= 3'd0;
      r_gap_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (stop && (r_state != S_IDLE)) begin
        // Abort: note_idx is left where it stopped for debug visibility.
        r_state    <= S_IDLE;
        busy       <= 1'b0;
        buzz_en    <= 1'b0;
        r_beat_cnt <= '0;
        r_beat_num <= 3'd0;
        r_gap_cnt  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !stop) begin
              r_state  <= S_FETCH;
              note_idx <= '0;
              busy     <= 1'b1;
            end
          end
          S_FETCH: begin
            if (w_tone == TONE_END) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state    <= S_PLAY;
              tone       <= w_tone;
              buzz_en    <= audible(w_tone);
              r_beat_cnt <= '0;
              r_beat_num <= 3'd0;
            end
          end
          S_PLAY: begin
            if (r_beat_cnt == BEAT_LAST) begin
              r_beat_cnt <= '0;
              if (r_beat_num == r_dur) begin
                r_beat_num <= 3'd0;
                buzz_en    <= 1'b0;
                if (GAP_CYC > 1) begin
                  r_state <= S_GAP;
                end else begin
                  r_state <= w_last ? S_DONE : S_FETCH;
                  done    <= w_last;
                  if (!w_last) note_idx <= note_idx + 1'b1;
                end
              end else begin
                r_beat_num <= r_beat_num + 3'd1;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
              r_gap_cnt <= '0;
              r_state   <= w_last ? S_DONE : S_FETCH;
              done      <= w_last;
              if (!w_last) note_idx <= note_idx + 1'b1;
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end
          S_DONE: begin
            if (w_loop) begin
              r_state  <= S_FETCH;
              note_idx <= '0;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            buzz_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_player.sv
// Bench for buzzer_player with short beats; the expected output timeline is rebuilt from the note table.
module tb_buzzer_player;
  localparam int BEAT = 10;
  localparam int GAP  = 2;
  localparam int LEN  = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
`ifdef PLAYER_LOOP_EN
  logic loop = 1'b0;
`endif
  logic          busy, done, buzz_en;
  logic [4:0]    tone;
  logic [AW-1:0] note_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  tone_tab [LEN];
  logic [2:0]  dur_tab  [LEN];
  logic [12:0] q [$];
  logic [4:0]  m_tone = 5'd0;

  always #5 clk = ~clk;

  buzzer_player #(
    .BEAT_CYC (BEAT),
    .GAP_CYC  (GAP),
    .SONG_LEN (LEN),
    .ADDR_W   (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
`ifdef PLAYER_LOOP_EN
    .loop     (loop),
`endif
    .busy     (busy),
    .done     (done),
    .buzz_en  (buzz_en),
    .tone     (tone),
    .note_idx (note_idx)
  );

  function automatic logic [12:0] obs();
    return {busy, done, buzz_en, tone, note_idx};
  endfunction

  function automatic logic [12:0] pack(input logic b, input logic d, input logic z,
                                      input logic [4:0] t, input logic [4:0] i);
    return {b, d, z, t, i};
  endfunction

  // Expected cycle-by-cycle outputs from the cycle after the start edge through the DONE cycle.
  task automatic build(input logic [4:0] prev);
    logic [4:0] t;
    int n;
    q.delete();
    t = prev;
    q.push_back(pack(1'b1, 1'b0, 1'b0, t, 5'd0));
    for (int e = 0; e < LEN; e++) begin
      if (tone_tab[e] == 5'd31) begin
        q.push_back(pack(1'b1, 1'b1, 1'b0, t, 5'(e)));
        break;
      end
      t = tone_tab[e];
      n = (int'(dur_tab[e]) + 1) * BEAT;
      for (int k = 0; k < n; k++) q.push_back(pack(1'b1, 1'b0, (t >= 5'd1 && t <= 5'd21), t, 5'(e)));
      for (int k = 0; k < GAP - 1; k++) q.push_back(pack(1'b1, 1'b0, 1'b0, t, 5'(e)));
      if (e == LEN - 1) begin
        q.push_back(pack(1'b1, 1'b1, 1'b0, t, 5'(e)));
        break;
      end
      q.push_back(pack(1'b1, 1'b0, 1'b0, t, 5'(e + 1)));
    end
  endtask

  task automatic run_song(input int stop_at, input int restart_at);
    logic [12:0] got, e;
    build(m_tone);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int p = 0; p < q.size(); p++) begin
      e = q[p];
      got = obs();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL trace p=%0d got=%h exp=%h", p, got, e);
      end
      if (p == stop_at) begin
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        got = obs();
        n_checks++;
        if (got !== pack(1'b0, 1'b0, 1'b0, e[9:5], e[4:0])) begin
          n_fail++;
          $display("FAIL stop_abort p=%0d got=%h exp=%h", p, got, pack(1'b0, 1'b0, 1'b0, e[9:5], e[4:0]));
        end
        m_tone = e[9:5];
        return;
      end
      start = (p == restart_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    e = q[q.size() - 1];
    m_tone = e[9:5];
    repeat (3) begin
      got = obs();
      n_checks++;
      if (got !== pack(1'b0, 1'b0, 1'b0, e[9:5], e[4:0])) begin
        n_fail++;
        $display("FAIL idle_after got=%h exp=%h", got, pack(1'b0, 1'b0, 1'b0, e[9:5], e[4:0]));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs() !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=%h", obs(), 13'd0);
    end
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs() !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_idle got=%h exp=%h", obs(), 13'd0);
      end
    end
  endtask

  task automatic test_full_song();
    int first_play;
    first_play = 0;
    build(m_tone);
    for (int p = 0; p < q.size(); p++) if (q[p][10] && first_play == 0) first_play = p;
    n_checks++;
    if (first_play !== 1) begin
      n_fail++;
      $display("FAIL model_latency got=%0d exp=%0d", first_play, 1);
    end
    run_song(-1, -1);
  endtask

  task automatic test_stop();
    int s;
    s = 37 + $urandom_range(0, 9);
    run_song(s, -1);
    repeat (5) begin
      @(posedge clk); #1;
      n_checks++;
      if ({busy, done, buzz_en} !== 3'b000) begin
        n_fail++;
        $display("FAIL stop_quiet got=%b exp=%b", {busy, done, buzz_en}, 3'b000);
      end
    end
    run_song(-1, -1);
  endtask

  task automatic test_start_ignored();
    logic [12:0] held;
    run_song(-1, 25 + $urandom_range(0, 9));
    held = obs();
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) begin
      n_checks++;
      if (obs() !== held || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL start_stop_idle got=%h exp=%h", obs(), held);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    int k;
    k = $urandom_range(5, 100);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (k) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 13'd0) begin
      n_fail++;
      $display("FAIL async_reset k=%0d got=%h exp=%h", k, obs(), 13'd0);
    end
    #1;
    rst = 1'b0;
    m_tone = 5'd0;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs() !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_stays_idle got=%h exp=%h", obs(), 13'd0);
      end
    end
    run_song(-1, -1);
  endtask

  task automatic test_random();
    int s, r;
    repeat (4) begin
      s = $urandom_range(0, 130);
      r = $urandom_range(0, 130);
      run_song(s, r);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
  endtask

`ifdef PLAYER_LOOP_EN
  task automatic test_loop();
    logic [12:0] got, e;
    build(m_tone);
    loop  = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int p = 0; p < q.size(); p++) begin
      got = obs();
      n_checks++;
      if (got !== q[p]) begin
        n_fail++;
        $display("FAIL loop_trace p=%0d got=%h exp=%h", p, got, q[p]);
      end
      @(posedge clk); #1;
    end
    e = q[q.size() - 1];
    n_checks++;
    if (obs() !== pack(1'b1, 1'b0, 1'b0, e[9:5], 5'd0)) begin
      n_fail++;
      $display("FAIL loop_refetch got=%h exp=%h", obs(), pack(1'b1, 1'b0, 1'b0, e[9:5], 5'd0));
    end
    @(posedge clk); #1;
    n_checks++;
    if (obs() !== pack(1'b1, 1'b0, 1'b1, tone_tab[0], 5'd0)) begin
      n_fail++;
      $display("FAIL loop_replay got=%h exp=%h", obs(), pack(1'b1, 1'b0, 1'b1, tone_tab[0], 5'd0));
    end
    loop = 1'b0;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_stop got=%b exp=%b", busy, 1'b0);
    end
    m_tone = tone_tab[0];
  endtask
`endif

  initial begin
    for (int e = 0; e < LEN; e++) begin
      tone_tab[e] = 5'd31;
      dur_tab[e]  = 3'd0;
    end
    tone_tab[0] = 5'd8;
    tone_tab[1] = 5'd8;
    tone_tab[2] = 5'd12;
    tone_tab[3] = 5'd12;
    tone_tab[4] = 5'd13;
    tone_tab[5] = 5'd13;
    tone_tab[6] = 5'd12;
    dur_tab[6]  = 3'd1;
    tone_tab[7] = 5'd0;

    test_reset();
    test_full_song();
    test_stop();
    test_start_ignored();
    test_async_reset();
    test_random();
`ifdef PLAYER_LOOP_EN
    test_loop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
